qs_egress: RTL and testbench

- Sits directly downstream of the qs sort engine and consumes its sorted output stream (vld/sop/eop/err/dat).
- qs output has no backpressure, so this block buffers packets in a FIFO and re-emits them on a valid/ready interface.
- Checks packet framing, sort order and length in flight, tags violations on the output err bit, and keeps status counters.

---
 rtl/qs_egress_if.sv | 34 +++
 rtl/qs_egress.sv | 146 ++++++++++++++
 tb/tb_qs_egress.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/qs_egress_if.sv
// Stream bundle between qs_egress and its neighbours: qs-side input beats,
// valid/ready output head, and status counters.
interface qs_egress_if #(
  parameter int W = 32
);
  logic         in_vld;
  logic         in_sop;
  logic         in_eop;
  logic         in_err;
  logic [W-1:0] in_dat;

  logic         out_vld_r;
  logic         out_sop_r;
  logic         out_eop_r;
  logic         out_err_r;
  logic [W-1:0] out_dat_r;
  logic         out_rdy;

  logic [15:0]  st_pkt_cnt;
  logic [15:0]  st_err_cnt;
  logic         st_ovf_r;

  modport master (
    output in_vld, in_sop, in_eop, in_err, in_dat, out_rdy,
    input  out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r,
    input  st_pkt_cnt, st_err_cnt, st_ovf_r
  );

  modport slave (
    input  in_vld, in_sop, in_eop, in_err, in_dat, out_rdy,
    output out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r,
    output st_pkt_cnt, st_err_cnt, st_ovf_r
  );
endinterface

// File: rtl/qs_egress.sv
// Egress buffer for the qs sort engine: framing/order/length checks, FIFO, registered head.
// Define QS_EGRESS_SIGNED_EN to make the order check a signed compare.
module qs_egress #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int MAX_N = 64
) (
  input  logic        clk,
  input  logic        rst,
  qs_egress_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_N + 2);

  typedef enum logic {IDLE, PKT} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    last_dat;
  logic [LW-1:0]   len;
  logic            pkt_err, len_flag, ovf_flag;
  logic [W+2:0]    mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;

  logic            accept, stray, restart, order_viol;
  logic            lt, len_viol, len_cnt, ovf_cnt;
  logic            pkt_err_base, ovf_base, word_err;
  logic            pop, full, drop, push, avail;
  logic [LW-1:0]   len_nx;
  logic [AW:0]     used, rd_nx;
  logic [2:0]      err_inc;
  logic [16:0]     err_sum;

`ifdef QS_EGRESS_SIGNED_EN
  assign lt = $signed(bus.in_dat) < $signed(last_dat);
`else
  assign lt = bus.in_dat < last_dat;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    stray      = 1'b0;
    restart    = 1'b0;
    order_viol = 1'b0;
    if (bus.in_vld) begin
      unique case (state)
        IDLE: begin
          if (bus.in_sop) begin
            accept   = 1'b1;
            state_nx = bus.in_eop ? IDLE : PKT;
          end else begin
            stray = 1'b1;
          end
        end
        PKT: begin
          accept     = 1'b1;
          restart    = bus.in_sop;
          order_viol = !bus.in_sop && lt;
          state_nx   = bus.in_eop ? IDLE : PKT;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Length saturates one past MAX_N so the over-length flag stays asserted.
  assign len_nx = bus.in_sop ? LW'(1)
                : (len == LW'(MAX_N + 1)) ? len : len + LW'(1);
  assign len_viol     = accept && (len_nx > LW'(MAX_N));
  assign len_cnt      = len_viol && !len_flag;
  assign pkt_err_base = bus.in_sop ? 1'b0 : pkt_err;
  assign ovf_base     = bus.in_sop ? 1'b0 : ovf_flag;

  assign used  = wr_ptr - rd_ptr;
  assign full  = (used == (AW + 1)'(DEPTH));
  assign pop   = bus.out_vld_r && bus.out_rdy;
  assign drop  = accept && full && !pop;
  assign push  = accept && !drop;
  assign ovf_cnt = drop && !ovf_base;

  assign word_err = bus.in_err | order_viol | len_viol | restart
                  | (bus.in_eop & pkt_err_base);

  assign err_inc = 3'(stray) + 3'(restart) + 3'(order_viol) + 3'(len_cnt) + 3'(ovf_cnt);
  assign err_sum = {1'b0, bus.st_err_cnt} + 17'(err_inc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dat <= '0;
      len      <= '0;
      pkt_err  <= 1'b0;
      len_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else if (accept) begin
      last_dat <= bus.in_dat;
      len      <= len_nx;
      len_flag <= bus.in_eop ? 1'b0 : ((bus.in_sop ? 1'b0 : len_flag) | len_viol);
      pkt_err  <= bus.in_eop ? 1'b0 : (pkt_err_base | order_viol | drop);
      ovf_flag <= bus.in_eop ? 1'b0 : (ovf_base | drop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.st_pkt_cnt <= '0;
      bus.st_err_cnt <= '0;
      bus.st_ovf_r   <= 1'b0;
    end else begin
      if (push && bus.in_eop) bus.st_pkt_cnt <= bus.st_pkt_cnt + 16'd1;
      bus.st_err_cnt <= err_sum[16] ? '1 : err_sum[15:0];
      if (drop) bus.st_ovf_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.in_sop, bus.in_eop, word_err, bus.in_dat};
  end

  // Head reloads from storage as it stands after this cycle's pop; a word
  // written this edge becomes visible one edge later.
  assign rd_nx = rd_ptr + (AW + 1)'(pop);
  assign avail = (wr_ptr != rd_nx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.out_vld_r <= 1'b0;
      bus.out_sop_r <= 1'b0;
      bus.out_eop_r <= 1'b0;
      bus.out_err_r <= 1'b0;
      bus.out_dat_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      rd_ptr        <= rd_nx;
      bus.out_vld_r <= avail;
      if (avail)
        {bus.out_sop_r, bus.out_eop_r, bus.out_err_r, bus.out_dat_r} <= mem[rd_nx[AW-1:0]];
    end
  end
endmodule

// File: tb/tb_qs_egress.sv
// Bench for qs_egress: directed scenarios plus randomized packets checked against a beat-level model.
module tb_qs_egress;
  localparam int DEPTH = 16;
  localparam int MAX_N = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  qs_egress_if #(.W(32)) bus ();

  qs_egress #(.W(32), .DEPTH(DEPTH), .MAX_N(MAX_N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        err;
    logic [31:0] dat;
  } ent_t;

  ent_t        q[$];
  bit          m_vld, m_in_pkt, m_pkt_err, m_len_flag, m_ovf_flag, m_ovf;
  logic [31:0] m_last;
  int          m_len, m_pkt_cnt, m_err_cnt;

  function automatic bit m_less(input logic [31:0] a, input logic [31:0] b);
`ifdef QS_EGRESS_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_vld = 0; m_in_pkt = 0; m_pkt_err = 0; m_len_flag = 0; m_ovf_flag = 0; m_ovf = 0;
    m_last = '0; m_len = 0; m_pkt_cnt = 0; m_err_cnt = 0;
  endtask

  task automatic model_edge(input bit vld, input bit sop, input bit eop, input bit err,
                            input logic [31:0] dat, input bit rdy);
    bit pop, full, nxt_vld, werr, set_pe, drop;
    int errs;
    pop  = m_vld && rdy;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    nxt_vld = (q.size() > 0);
    errs = 0;
    if (vld) begin
      if (!m_in_pkt && !sop) begin
        errs = 1;
      end else begin
        werr = err; set_pe = 0;
        if (m_in_pkt && sop) begin werr = 1; errs++; end
        if (sop) begin
          m_len = 1; m_pkt_err = 0; m_len_flag = 0; m_ovf_flag = 0;
        end else begin
          m_len++;
          if (m_less(dat, m_last)) begin werr = 1; errs++; set_pe = 1; end
        end
        if (m_len > MAX_N) begin
          werr = 1;
          if (!m_len_flag) begin errs++; m_len_flag = 1; end
        end
        if (eop && m_pkt_err) werr = 1;
        drop = full && !pop;
        if (drop) begin
          m_ovf = 1; set_pe = 1;
          if (!m_ovf_flag) begin errs++; m_ovf_flag = 1; end
        end else begin
          q.push_back('{sop: sop, eop: eop, err: werr, dat: dat});
          if (eop) m_pkt_cnt = (m_pkt_cnt + 1) % 65536;
        end
        m_pkt_err = m_pkt_err | set_pe;
        if (eop) begin
          m_pkt_err = 0; m_len_flag = 0; m_ovf_flag = 0; m_in_pkt = 0;
        end else begin
          m_in_pkt = 1;
        end
        m_last = dat;
      end
    end
    m_err_cnt = (m_err_cnt + errs > 65535) ? 65535 : m_err_cnt + errs;
    m_vld = nxt_vld;
  endtask

  task automatic check_outputs();
    chk("out_vld", 32'(bus.out_vld_r), 32'(m_vld));
    if (m_vld) begin
      chk("out_sop", 32'(bus.out_sop_r), 32'(q[0].sop));
      chk("out_eop", 32'(bus.out_eop_r), 32'(q[0].eop));
      chk("out_err", 32'(bus.out_err_r), 32'(q[0].err));
      chk("out_dat", bus.out_dat_r, q[0].dat);
    end
    chk("pkt_cnt", 32'(bus.st_pkt_cnt), 32'(m_pkt_cnt));
    chk("err_cnt", 32'(bus.st_err_cnt), 32'(m_err_cnt));
    chk("ovf",     32'(bus.st_ovf_r),   32'(m_ovf));
  endtask

  // One clock: drive, check state left by the previous edge, advance the model.
  task automatic cycle(input bit vld, input bit sop, input bit eop, input bit err,
                       input logic [31:0] dat, input bit rdy);
    bus.in_vld = vld; bus.in_sop = sop; bus.in_eop = eop; bus.in_err = err;
    bus.in_dat = dat; bus.out_rdy = rdy;
    @(negedge clk);
    check_outputs();
    model_edge(vld, sop, eop, err, dat, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_vld = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_err = 0; bus.in_dat = '0;
    @(negedge clk);
    model_reset();
    chk("rst_vld", 32'(bus.out_vld_r), 32'd0);
    chk("rst_pkt", 32'(bus.st_pkt_cnt), 32'd0);
    chk("rst_err", 32'(bus.st_err_cnt), 32'd0);
    chk("rst_ovf", 32'(bus.st_ovf_r), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, rdy);
  endtask

  initial begin
    logic [31:0] d;
    int          len, bias, rs_at;
    checks = 0;
    errors = 0;
    bus.out_rdy = 1'b1;
    do_reset();
    chk("rst_sop", 32'(bus.out_sop_r), 32'd0);
    chk("rst_eop", 32'(bus.out_eop_r), 32'd0);
    chk("rst_oerr", 32'(bus.out_err_r), 32'd0);
    chk("rst_dat", bus.out_dat_r, 32'd0);

    // Clean packet 3,5,5,9
    cycle(1, 1, 0, 0, 32'd3, 1);
    cycle(1, 0, 0, 0, 32'd5, 1);
    cycle(1, 0, 0, 0, 32'd5, 1);
    cycle(1, 0, 1, 0, 32'd9, 1);
    idle(4, 1);
    chk("tp1_pkt", 32'(bus.st_pkt_cnt), 32'd1);
    chk("tp1_err", 32'(bus.st_err_cnt), 32'd0);

    // Order violation 4,2,7 and signed-sensitive pair
    cycle(1, 1, 0, 0, 32'd4, 1);
    cycle(1, 0, 0, 0, 32'd2, 1);
    cycle(1, 0, 1, 0, 32'd7, 1);
    cycle(1, 1, 0, 0, 32'hFFFF_FFFF, 1);
    cycle(1, 0, 1, 0, 32'd1, 1);
    idle(4, 1);

    // Overflow: 18 ascending words with consumer stalled, then drain
    do_reset();
    for (int i = 0; i < 18; i++) cycle(1, i == 0, i == 17, 0, 32'(10 + i), 0);
    idle(3, 0);
    idle(22, 1);

    // Stray beat in IDLE then single-word packet
    do_reset();
    cycle(1, 0, 0, 0, 32'h11, 1);
    idle(2, 1);
    chk("tp4_err", 32'(bus.st_err_cnt), 32'd1);
    cycle(1, 1, 1, 0, 32'h22, 1);
    idle(3, 1);
    chk("tp4_pkt", 32'(bus.st_pkt_cnt), 32'd1);

    // Restart mid-packet, then over-length packet, then reset mid-packet
    cycle(1, 1, 0, 0, 32'd1, 1);
    cycle(1, 0, 0, 0, 32'd2, 1);
    cycle(1, 1, 0, 0, 32'd0, 1);
    cycle(1, 0, 1, 0, 32'd5, 1);
    idle(3, 1);
    for (int i = 0; i < MAX_N + 2; i++) cycle(1, i == 0, i == MAX_N + 1, i == 1, 32'(i), 1);
    cycle(1, 1, 0, 0, 32'd50, 1);
    cycle(1, 0, 0, 0, 32'd51, 0);
    do_reset();
    cycle(1, 1, 0, 0, 32'd7, 1);
    cycle(1, 0, 1, 0, 32'd8, 1);
    idle(3, 1);

    // Randomized packets with varying backpressure
    bias = 80;
    for (int p = 0; p < 200; p++) begin
      if (p % 25 == 0) bias = $urandom_range(5, 100);
      if ($urandom_range(0, 99) < 2) do_reset();
      if ($urandom_range(0, 99) < 5)
        cycle(1, 0, $urandom_range(0, 1), 0, $urandom(), $urandom_range(0, 99) < bias);
      len   = $urandom_range(1, 10);
      rs_at = ($urandom_range(0, 99) < 6) ? $urandom_range(1, 9) : 99;
      d     = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 40));
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 99) < 20) cycle(0, 0, 0, 0, $urandom(), $urandom_range(0, 99) < bias);
        cycle(1, i == 0 || i == rs_at, i == len - 1, $urandom_range(0, 99) < 5, d,
              $urandom_range(0, 99) < bias);
        if ($urandom_range(0, 99) < 10) d = d - 32'($urandom_range(1, 5));
        else                            d = d + 32'($urandom_range(0, 3));
      end
    end
    idle(DEPTH + 8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
